// File: rtl/dcache_write_buffer.sv
// Dirty-line write buffer between dcache and memory: FIFO of evicted lines with
// miss-lookup forwarding, same-line write coalescing and a two-state drain FSM.
module dcache_write_buffer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ADDR_SIZE   = 32,
  parameter int unsigned LINE_SIZE   = 256,
  parameter int unsigned OFFSET_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dcache_write_buffer_en,
  input  logic [ADDR_SIZE-1:0] dcache_write_buffer_physical_addr,
  input  logic [LINE_SIZE-1:0] dcache_write_buffer_data,
  output logic                 buffer_ready_for_dcache_write,
  output logic                 buffer_receive_dcache_write_ok,
  input  logic                 dcache_read_mem_en,
  input  logic [ADDR_SIZE-1:0] dcache_read_mem_addr,
  output logic                 buffer_hit_success,
  output logic [LINE_SIZE-1:0] buffer_hit_data,
  output logic                 buffer_write_mem_en,
  output logic [ADDR_SIZE-1:0] buffer_write_mem_addr,
  output logic [LINE_SIZE-1:0] buffer_write_mem_data,
  input  logic                 mem_ready_for_buffer_write,
  input  logic                 mem_receive_buffer_write_ok,
  output logic                 buffer_empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    BUF_IDLE = 2'b01,
    BUF_SEND = 2'b10
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [DEPTH-1:0]       r_valid;
  logic [ADDR_SIZE-1:0]   r_addr [DEPTH];
  logic [LINE_SIZE-1:0]   r_data [DEPTH];
  logic [PTR_W-1:0]       r_head, r_tail;
  logic [PTR_W:0]         r_count;
  logic                   r_recv_ok;
  logic [ADDR_SIZE-1:0]   r_wm_addr;
  logic [LINE_SIZE-1:0]   r_wm_data;

  logic                   w_coal_hit, w_hit;
  logic [PTR_W-1:0]       w_coal_idx, w_hit_idx, w_idx;
  logic                   w_accept, w_push, w_pop, w_launch;
  logic [LINE_SIZE-1:0]   w_launch_data;

  // Walk entries oldest to newest so the last match found is the newest one.
  always_comb begin
    w_coal_hit = 1'b0;
    w_coal_idx = r_head;
    w_hit      = 1'b0;
    w_hit_idx  = r_head;
    w_idx      = r_head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (dcache_write_buffer_en && r_valid[w_idx] &&
          (r_addr[w_idx][ADDR_SIZE-1:OFFSET_SIZE] ==
           dcache_write_buffer_physical_addr[ADDR_SIZE-1:OFFSET_SIZE]) &&
          !((r_state == BUF_SEND) && (w_idx == r_head))) begin
        w_coal_hit = 1'b1;
        w_coal_idx = w_idx;
      end
      if (dcache_read_mem_en && r_valid[w_idx] &&
          (r_addr[w_idx][ADDR_SIZE-1:OFFSET_SIZE] ==
           dcache_read_mem_addr[ADDR_SIZE-1:OFFSET_SIZE])) begin
        w_hit     = 1'b1;
        w_hit_idx = w_idx;
      end
    end
  end

  assign buffer_ready_for_dcache_write  = (r_count < CNT_FULL) || w_coal_hit;
  assign buffer_receive_dcache_write_ok = r_recv_ok;
  assign buffer_hit_success             = w_hit;
  assign buffer_hit_data                = w_hit ? r_data[w_hit_idx] : '0;
  assign buffer_write_mem_addr          = r_wm_addr;
  assign buffer_write_mem_data          = r_wm_data;
  assign buffer_empty                   = (r_count == '0);

  assign w_accept = dcache_write_buffer_en && buffer_ready_for_dcache_write;
  assign w_push   = w_accept && !w_coal_hit;
  assign w_pop    = (r_state == BUF_SEND) && mem_receive_buffer_write_ok;

  always_comb begin
    w_state_nxt         = r_state;
    buffer_write_mem_en = 1'b0;
    case (r_state)
      BUF_IDLE: if ((r_count != '0) && mem_ready_for_buffer_write) w_state_nxt = BUF_SEND;
      BUF_SEND: begin
        buffer_write_mem_en = 1'b1;
        if (mem_receive_buffer_write_ok) w_state_nxt = BUF_IDLE;
      end
      default: w_state_nxt = BUF_IDLE;
    endcase
  end

  assign w_launch = (r_state == BUF_IDLE) && (w_state_nxt == BUF_SEND);
  // A coalesce into the head on the launch edge must reach memory, not the stale copy.
  assign w_launch_data = (w_accept && w_coal_hit && (w_coal_idx == r_head)) ?
                         dcache_write_buffer_data : r_data[r_head];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= BUF_IDLE;
      r_valid   <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_recv_ok <= 1'b0;
      r_wm_addr <= '0;
      r_wm_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_recv_ok <= w_accept;
      if (w_launch) begin
        r_wm_addr <= r_addr[r_head];
        r_wm_data <= w_launch_data;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= dcache_write_buffer_physical_addr;
      r_data[r_tail] <= dcache_write_buffer_data;
    end else if (w_accept) begin
      r_data[w_coal_idx] <= dcache_write_buffer_data;
    end
  end
endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer: cycle vector table for push/lookup/coalesce/drain,
// plus hand sequences for full-buffer stall, head-in-flight writes and mid-drain reset.
module tb_dcache_write_buffer;
  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [31:0]  wr_addr;
  logic [255:0] wr_data;
  logic         ready, rok;
  logic         rd_en;
  logic [31:0]  rd_addr;
  logic         hit;
  logic [255:0] hit_data;
  logic         wen;
  logic [31:0]  waddr;
  logic [255:0] wdata;
  logic         mem_ready, mem_ok;
  logic         empty;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dcache_write_buffer #(.DEPTH(4), .ADDR_SIZE(32), .LINE_SIZE(256), .OFFSET_SIZE(4)) dut (
    .clk                               (clk),
    .reset                             (reset),
    .dcache_write_buffer_en            (wr_en),
    .dcache_write_buffer_physical_addr (wr_addr),
    .dcache_write_buffer_data          (wr_data),
    .buffer_ready_for_dcache_write     (ready),
    .buffer_receive_dcache_write_ok    (rok),
    .dcache_read_mem_en                (rd_en),
    .dcache_read_mem_addr              (rd_addr),
    .buffer_hit_success                (hit),
    .buffer_hit_data                   (hit_data),
    .buffer_write_mem_en               (wen),
    .buffer_write_mem_addr             (waddr),
    .buffer_write_mem_data             (wdata),
    .mem_ready_for_buffer_write        (mem_ready),
    .mem_receive_buffer_write_ok       (mem_ok),
    .buffer_empty                      (empty)
  );

  typedef struct {
    logic        we;
    logic [31:0] wa;
    logic [7:0]  wk;
    logic        re;
    logic [31:0] ra;
    logic        mr;
    logic        mok;
    logic        e_ready;
    logic        e_rok;
    logic        e_hit;
    logic [7:0]  e_hk;
    logic        e_wen;
    logic [31:0] e_wa;
    logic [7:0]  e_wk;
    logic        e_empty;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [255:0] d(input logic [7:0] k);
    return {32{k}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    mem_ready = 1'b0; mem_ok = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Waits (bounded) for a drain request, checks it, acknowledges it, checks the idle gap.
  task automatic drain(input logic [31:0] a, input logic [7:0] k);
    int n;
    n = 0;
    while (wen !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_request", wen, 1'b1);
    if (wen === 1'b1) begin
      chk("drain_addr", waddr, a);
      chk("drain_data", wdata, d(k));
      mem_ok = 1'b1;
      @(negedge clk);
      mem_ok = 1'b0;
      #1;
      chk("drain_idle_gap", wen, 1'b0);
    end
  endtask

  initial begin
    //          we wa       wk re ra       mr mok rdy rok hit hk wen ewa      ewk emp
    vecs[0] = '{1, 32'h100, 1, 0, 32'h0,   0, 0,  1,  0,  0,  0, 0,  32'h0,   0,  1};
    vecs[1] = '{0, 32'h0,   0, 1, 32'h10C, 0, 0,  1,  1,  1,  1, 0,  32'h0,   0,  0};
    vecs[2] = '{0, 32'h0,   0, 1, 32'h200, 0, 0,  1,  0,  0,  0, 0,  32'h0,   0,  0};
    vecs[3] = '{1, 32'h100, 2, 1, 32'h100, 0, 0,  1,  0,  1,  1, 0,  32'h0,   0,  0};
    vecs[4] = '{0, 32'h0,   0, 1, 32'h100, 0, 0,  1,  1,  1,  2, 0,  32'h0,   0,  0};
    vecs[5] = '{0, 32'h0,   0, 0, 32'h0,   1, 0,  1,  0,  0,  0, 0,  32'h0,   0,  0};
    vecs[6] = '{0, 32'h0,   0, 0, 32'h0,   0, 0,  1,  0,  0,  0, 1,  32'h100, 2,  0};
    vecs[7] = '{0, 32'h0,   0, 0, 32'h0,   0, 1,  1,  0,  0,  0, 1,  32'h100, 2,  0};
    vecs[8] = '{0, 32'h0,   0, 1, 32'h100, 0, 0,  1,  0,  0,  0, 0,  32'h0,   0,  1};

    reset = 1'b0;
    clear_inputs();
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_wen", wen, 1'b0);
    chk("rst_hit", hit, 1'b0);
    chk("rst_rok", rok, 1'b0);
    chk("rst_waddr", waddr, 32'h0);
    chk("rst_wdata", wdata, 256'h0);
    chk("rst_hit_data", hit_data, 256'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_ready", ready, 1'b1);
    chk("post_rst_empty", empty, 1'b1);
    chk("post_rst_wen", wen, 1'b0);

    // Single push, lookups, coalesce, drain of coalesced line.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = d(vecs[i].wk);
      rd_en = vecs[i].re; rd_addr = vecs[i].ra;
      mem_ready = vecs[i].mr; mem_ok = vecs[i].mok;
      #1;
      chk($sformatf("v%0d_ready", i), ready, vecs[i].e_ready);
      chk($sformatf("v%0d_rok", i), rok, vecs[i].e_rok);
      chk($sformatf("v%0d_hit", i), hit, vecs[i].e_hit);
      chk($sformatf("v%0d_hit_data", i), hit_data, d(vecs[i].e_hk));
      chk($sformatf("v%0d_wen", i), wen, vecs[i].e_wen);
      chk($sformatf("v%0d_empty", i), empty, vecs[i].e_empty);
      if (vecs[i].e_wen) begin
        chk($sformatf("v%0d_waddr", i), waddr, vecs[i].e_wa);
        chk($sformatf("v%0d_wdata", i), wdata, d(vecs[i].e_wk));
      end
    end

    // Fill to DEPTH, stall a fifth push, pop frees a slot, FIFO order preserved.
    reset_dut();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 32'h100 * i; wr_data = d(8'(i));
      #1;
      chk("fill_ready", ready, 1'b1);
      @(negedge clk);
      wr_en = 1'b0;
      #1;
      chk("fill_rok", rok, 1'b1);
    end
    chk("full_ready", ready, 1'b0);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 32'h500; wr_data = d(5); mem_ready = 1'b1;
    #1;
    chk("full_push_held", ready, 1'b0);
    chk("full_wen_idle", wen, 1'b0);
    @(negedge clk);
    #1;
    chk("full_send_wen", wen, 1'b1);
    chk("full_send_addr", waddr, 32'h100);
    chk("full_send_data", wdata, d(1));
    chk("full_pop_cycle_ready", ready, 1'b0);
    mem_ok = 1'b1;
    @(negedge clk);
    mem_ok = 1'b0;
    #1;
    chk("after_pop_ready", ready, 1'b1);
    chk("after_pop_rok", rok, 1'b0);
    chk("after_pop_wen", wen, 1'b0);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 32'h504;
    #1;
    chk("held_push_rok", rok, 1'b1);
    chk("held_push_hit", hit, 1'b1);
    chk("held_push_hit_data", hit_data, d(5));
    rd_en = 1'b0;
    drain(32'h200, 2);
    drain(32'h300, 3);
    drain(32'h400, 4);
    drain(32'h500, 5);
    chk("full_drained_empty", empty, 1'b1);

    // Write to the head line while it is in flight becomes a new entry.
    reset_dut();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 32'h100; wr_data = d(3);
    @(negedge clk);
    wr_en = 1'b0; mem_ready = 1'b1;
    #1;
    chk("inflight_first_rok", rok, 1'b1);
    @(negedge clk);
    mem_ready = 1'b0;
    wr_en = 1'b1; wr_addr = 32'h100; wr_data = d(4);
    rd_en = 1'b1; rd_addr = 32'h100;
    #1;
    chk("inflight_wen", wen, 1'b1);
    chk("inflight_ready", ready, 1'b1);
    chk("inflight_hit_old", hit_data, d(3));
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    chk("inflight_rok", rok, 1'b1);
    chk("inflight_hit_newest", hit_data, d(4));
    chk("inflight_data_stable", wdata, d(3));
    rd_en = 1'b0;
    drain(32'h100, 3);
    mem_ready = 1'b1;
    drain(32'h100, 4);
    chk("inflight_empty", empty, 1'b1);

    // Asynchronous reset in the middle of a drain.
    reset_dut();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 32'h100; wr_data = d(6); mem_ready = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_pre_wen", wen, 1'b1);
    reset = 1'b0;
    #1;
    chk("midrst_wen", wen, 1'b0);
    chk("midrst_empty", empty, 1'b1);
    chk("midrst_ready", ready, 1'b1);
    chk("midrst_waddr", waddr, 32'h0);
    @(negedge clk);
    reset = 1'b1; rd_en = 1'b1; rd_addr = 32'h100;
    #1;
    chk("midrst_lookup_miss", hit, 1'b0);
    chk("midrst_lookup_data", hit_data, 256'h0);
    @(negedge clk);
    #1;
    chk("midrst_stays_idle", wen, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
